// File: rtl/uart_pkg.sv
// Shared constants for the parametrised UART receive path: FSM encodings,
// parity mode selectors and a counter-width helper.
package uart_pkg;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_START  = 3'd1;
    localparam logic [2:0] ST_DATA   = 3'd2;
    localparam logic [2:0] ST_PARITY = 3'd3;
    localparam logic [2:0] ST_STOP   = 3'd4;
    localparam logic [2:0] ST_BREAK  = 3'd5;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_EVEN = 1;
    localparam int PARITY_ODD  = 2;

    // Width needed to index 0..value-1; never narrower than one bit.
    function automatic int cnt_width(input int value);
        return (value <= 2) ? 1 : $clog2(value);
    endfunction

endpackage

// File: rtl/uart_rx_core.sv
// UART character receiver: input synchronizer, bit-timing FSM, parity/stop
// checking and the registered rx_data / rx_valid / error pulse outputs.
module uart_rx_core
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 1736,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 0
) (
    input  logic                 CLK,
    input  logic                 reset,
    input  logic                 uart_rx,
    output logic                 accept,
    output logic [DATA_BITS-1:0] char_data,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 parity_err,
    output logic                 frame_err
);

    localparam int BW = cnt_width(CLKS_PER_BIT);
    localparam int CW = cnt_width(DATA_BITS + 1);
    localparam logic [BW-1:0] HALF_LOAD = BW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [BW-1:0] FULL_LOAD = BW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] LAST_BIT  = CW'(DATA_BITS - 1);
    localparam logic          ODD_SEL   = (PARITY == PARITY_ODD);

    logic                 rx_meta;
    logic                 rxs;
    logic                 rxs_d;
    logic [2:0]           state;
    logic [BW-1:0]        baud_cnt;
    logic [CW-1:0]        bit_cnt;
    logic [DATA_BITS-1:0] shift_in;
    logic                 par_bad;

    // The top level commits history on the same edge rx_valid is registered.
    assign accept    = (state == ST_STOP) && (baud_cnt == '0) && rxs && !par_bad;
    assign char_data = shift_in;

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            rx_meta    <= 1'b1;
            rxs        <= 1'b1;
            rxs_d      <= 1'b1;
            state      <= ST_IDLE;
            baud_cnt   <= '0;
            bit_cnt    <= '0;
            shift_in   <= '0;
            par_bad    <= 1'b0;
            rx_data    <= '0;
            rx_valid   <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            rx_meta    <= uart_rx;
            rxs        <= rx_meta;
            rxs_d      <= rxs;
            rx_valid   <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;

            case (state)
                ST_IDLE: begin
                    if (rxs_d && !rxs) begin
                        state    <= ST_START;
                        baud_cnt <= HALF_LOAD;
                    end
                end
                ST_START: begin
                    if (baud_cnt != '0) begin
                        baud_cnt <= baud_cnt - BW'(1);
                    end else if (rxs) begin
                        state <= ST_IDLE;
                    end else begin
                        state    <= ST_DATA;
                        baud_cnt <= FULL_LOAD;
                        bit_cnt  <= '0;
                        par_bad  <= 1'b0;
                    end
                end
                ST_DATA: begin
                    if (baud_cnt != '0) begin
                        baud_cnt <= baud_cnt - BW'(1);
                    end else begin
                        shift_in <= {rxs, shift_in[DATA_BITS-1:1]};
                        baud_cnt <= FULL_LOAD;
                        if (bit_cnt == LAST_BIT) begin
                            state <= (PARITY != PARITY_NONE) ? ST_PARITY : ST_STOP;
                        end else begin
                            bit_cnt <= bit_cnt + CW'(1);
                        end
                    end
                end
                ST_PARITY: begin
                    if (baud_cnt != '0) begin
                        baud_cnt <= baud_cnt - BW'(1);
                    end else begin
                        par_bad  <= (^shift_in) ^ rxs ^ ODD_SEL;
                        baud_cnt <= FULL_LOAD;
                        state    <= ST_STOP;
                    end
                end
                ST_STOP: begin
                    if (baud_cnt != '0) begin
                        baud_cnt <= baud_cnt - BW'(1);
                    end else if (!rxs) begin
                        frame_err <= 1'b1;
                        state     <= ST_BREAK;
                    end else if (par_bad) begin
                        parity_err <= 1'b1;
                        state      <= ST_IDLE;
                    end else begin
                        rx_valid <= 1'b1;
                        rx_data  <= shift_in;
                        state    <= ST_IDLE;
                    end
                end
                // A held-low line reports one frame error, then waits for idle.
                ST_BREAK: begin
                    if (rxs) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/uart_rx_shiftreg.sv
// UART receiver feeding a DEPTH-entry character history with a saturating
// fill count, synchronous clear and an LED mirror of the newest character.
module uart_rx_shiftreg
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 1736,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 0,
    parameter int DEPTH        = 4
) (
    input  logic                           CLK,
    input  logic                           reset,
    input  logic                           uart_rx,
    input  logic                           sr_clear,
    output logic [DATA_BITS-1:0]           rx_data,
    output logic                           rx_valid,
    output logic                           parity_err,
    output logic                           frame_err,
    output logic [DEPTH*DATA_BITS-1:0]     sr_data,
    output logic [cnt_width(DEPTH+1)-1:0]  sr_count,
    output logic [7:0]                     led
);

    localparam int NW = cnt_width(DEPTH + 1);

    logic                 accept;
    logic [DATA_BITS-1:0] char_data;

    uart_rx_core #(
        .CLKS_PER_BIT (CLKS_PER_BIT),
        .DATA_BITS    (DATA_BITS),
        .PARITY       (PARITY)
    ) u_core (
        .CLK        (CLK),
        .reset      (reset),
        .uart_rx    (uart_rx),
        .accept     (accept),
        .char_data  (char_data),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .parity_err (parity_err),
        .frame_err  (frame_err)
    );

    // Clear has priority over an accept on the same edge; the character is
    // still reported on rx_data but never enters the history.
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            sr_data  <= '0;
            sr_count <= '0;
            led      <= '0;
        end else if (sr_clear) begin
            sr_data  <= '0;
            sr_count <= '0;
            led      <= '0;
        end else if (accept) begin
            sr_data <= {sr_data[(DEPTH-1)*DATA_BITS-1:0], char_data};
            led     <= 8'(char_data);
            if (sr_count != NW'(DEPTH)) begin
                sr_count <= sr_count + NW'(1);
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_shiftreg.sv
// Directed bench for uart_rx_shiftreg: one no-parity and one even-parity
// instance, frames driven bit by bit with hand-computed expectations.
module tb_uart_rx_shiftreg;
    import uart_pkg::*;

    localparam int CPB = 16;
    localparam int DW  = 8;
    localparam int DEP = 4;

    logic          CLK;
    logic          reset;
    logic          line0, line1;
    logic          clr0, clr1;

    logic [DW-1:0]     rx_data0, rx_data1;
    logic              rx_valid0, rx_valid1;
    logic              parity_err0, parity_err1;
    logic              frame_err0, frame_err1;
    logic [DEP*DW-1:0] sr_data0, sr_data1;
    logic [2:0]        sr_count0, sr_count1;
    logic [7:0]        led0, led1;

    int checks = 0;
    int errors = 0;
    int valid0 = 0, perr0 = 0, ferr0 = 0;
    int valid1 = 0, perr1 = 0, ferr1 = 0;
    int clash  = 0;
    int v_s, p_s, f_s;

    uart_rx_shiftreg #(
        .CLKS_PER_BIT (CPB), .DATA_BITS (DW), .PARITY (0), .DEPTH (DEP)
    ) dut (
        .CLK        (CLK),
        .reset      (reset),
        .uart_rx    (line0),
        .sr_clear   (clr0),
        .rx_data    (rx_data0),
        .rx_valid   (rx_valid0),
        .parity_err (parity_err0),
        .frame_err  (frame_err0),
        .sr_data    (sr_data0),
        .sr_count   (sr_count0),
        .led        (led0)
    );

    uart_rx_shiftreg #(
        .CLKS_PER_BIT (CPB), .DATA_BITS (DW), .PARITY (1), .DEPTH (DEP)
    ) dut_par (
        .CLK        (CLK),
        .reset      (reset),
        .uart_rx    (line1),
        .sr_clear   (clr1),
        .rx_data    (rx_data1),
        .rx_valid   (rx_valid1),
        .parity_err (parity_err1),
        .frame_err  (frame_err1),
        .sr_data    (sr_data1),
        .sr_count   (sr_count1),
        .led        (led1)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    always @(negedge CLK) begin
        if (rx_valid0)   valid0++;
        if (parity_err0) perr0++;
        if (frame_err0)  ferr0++;
        if (rx_valid1)   valid1++;
        if (parity_err1) perr1++;
        if (frame_err1)  ferr1++;
        if ((rx_valid0 && (parity_err0 || frame_err0)) ||
            (rx_valid1 && (parity_err1 || frame_err1)))
            clash++;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic setLine(input bit sel, input logic value);
        if (sel) line1 = value;
        else     line0 = value;
    endtask

    task automatic bitWait();
        repeat (CPB) @(negedge CLK);
    endtask

    // One frame: start, 8 data bits LSB first, optional parity, stop.
    task automatic applyStimulus(input bit sel, input logic [7:0] data, input bit use_par,
                                 input bit par_bit, input bit stop_bit);
        setLine(sel, 1'b0);
        bitWait();
        for (int i = 0; i < 8; i++) begin
            setLine(sel, data[i]);
            bitWait();
        end
        if (use_par) begin
            setLine(sel, par_bit);
            bitWait();
        end
        setLine(sel, stop_bit);
        bitWait();
    endtask

    task automatic snap0();
        v_s = valid0; p_s = perr0; f_s = ferr0;
    endtask

    task automatic snap1();
        v_s = valid1; p_s = perr1; f_s = ferr1;
    endtask

    logic [7:0] burst [5];

    initial begin
        burst = '{8'h7E, 8'h03, 8'h01, 8'h01, 8'hFE};
        reset = 1'b1;
        line0 = 1'b1;
        line1 = 1'b1;
        clr0  = 1'b0;
        clr1  = 1'b0;
        repeat (4) @(negedge CLK);

        checkOutput("reset_rx_data",  32'(rx_data0),  32'h0);
        checkOutput("reset_rx_valid", 32'(rx_valid0), 32'h0);
        checkOutput("reset_sr_data",  sr_data0,       32'h0);
        checkOutput("reset_sr_count", 32'(sr_count0), 32'h0);
        checkOutput("reset_led",      32'(led0),      32'h0);
        checkOutput("reset_state",    32'(dut.u_core.state), 32'(ST_IDLE));

        reset = 1'b0;
        repeat (8) @(negedge CLK);

        snap0();
        applyStimulus(1'b0, 8'hF4, 1'b0, 1'b0, 1'b1);
        repeat (8) @(negedge CLK);
        checkOutput("f4_valid_pulses", 32'(valid0 - v_s), 32'd1);
        checkOutput("f4_err_pulses",   32'((perr0 - p_s) + (ferr0 - f_s)), 32'd0);
        checkOutput("f4_rx_data",      32'(rx_data0),  32'hF4);
        checkOutput("f4_led",          32'(led0),      32'hF4);
        checkOutput("f4_sr_count",     32'(sr_count0), 32'd1);
        checkOutput("f4_sr_data",      sr_data0,       32'h0000_00F4);

        snap0();
        foreach (burst[i]) applyStimulus(1'b0, burst[i], 1'b0, 1'b0, 1'b1);
        repeat (8) @(negedge CLK);
        checkOutput("burst_valid_pulses", 32'(valid0 - v_s), 32'd5);
        checkOutput("burst_sr_data",      sr_data0,          32'h0301_01FE);
        checkOutput("burst_sr_count",     32'(sr_count0),    32'd4);
        checkOutput("burst_led",          32'(led0),         32'hFE);

        snap0();
        line0 = 1'b0;
        repeat (CPB / 4) @(negedge CLK);
        line0 = 1'b1;
        repeat (2 * CPB) @(negedge CLK);
        checkOutput("glitch_pulses", 32'((valid0 - v_s) + (perr0 - p_s) + (ferr0 - f_s)), 32'd0);
        checkOutput("glitch_state",  32'(dut.u_core.state), 32'(ST_IDLE));

        snap0();
        applyStimulus(1'b0, 8'h55, 1'b0, 1'b0, 1'b0);
        repeat (3 * CPB) @(negedge CLK);
        line0 = 1'b1;
        repeat (2 * CPB) @(negedge CLK);
        checkOutput("break_frame_pulses", 32'(ferr0 - f_s), 32'd1);
        checkOutput("break_valid_pulses", 32'(valid0 - v_s), 32'd0);
        checkOutput("break_sr_data",      sr_data0,          32'h0301_01FE);

        snap0();
        applyStimulus(1'b0, 8'hAA, 1'b0, 1'b0, 1'b1);
        repeat (8) @(negedge CLK);
        checkOutput("aa_valid_pulses", 32'(valid0 - v_s), 32'd1);
        checkOutput("aa_rx_data",      32'(rx_data0),     32'hAA);
        checkOutput("aa_sr_data",      sr_data0,          32'h0101_FEAA);

        snap1();
        applyStimulus(1'b1, 8'h01, 1'b1, 1'b0, 1'b1);
        repeat (8) @(negedge CLK);
        checkOutput("par_bad_perr_pulses",  32'(perr1 - p_s),  32'd1);
        checkOutput("par_bad_valid_pulses", 32'(valid1 - v_s), 32'd0);
        checkOutput("par_bad_sr_data",      sr_data1,          32'h0);
        checkOutput("par_bad_sr_count",     32'(sr_count1),    32'd0);

        snap1();
        applyStimulus(1'b1, 8'h01, 1'b1, 1'b1, 1'b1);
        repeat (8) @(negedge CLK);
        checkOutput("par_ok_valid_pulses", 32'(valid1 - v_s), 32'd1);
        checkOutput("par_ok_perr_pulses",  32'(perr1 - p_s),  32'd0);
        checkOutput("par_ok_rx_data",      32'(rx_data1),     32'h01);
        checkOutput("par_ok_sr_data",      sr_data1,          32'h0000_0001);

        snap0();
        fork
            applyStimulus(1'b0, 8'hC0, 1'b0, 1'b0, 1'b1);
            begin
                repeat (3 * CPB) @(negedge CLK);
                checkOutput("midchar_state", 32'(dut.u_core.state), 32'(ST_DATA));
                reset = 1'b1;
            end
        join
        repeat (4) @(negedge CLK);
        checkOutput("midchar_reset_sr_count", 32'(sr_count0), 32'd0);
        reset = 1'b0;
        repeat (8) @(negedge CLK);
        applyStimulus(1'b0, 8'hF0, 1'b0, 1'b0, 1'b1);
        repeat (8) @(negedge CLK);
        checkOutput("f0_valid_pulses", 32'(valid0 - v_s), 32'd1);
        checkOutput("f0_rx_data",      32'(rx_data0),     32'hF0);
        checkOutput("f0_sr_count",     32'(sr_count0),    32'd1);
        checkOutput("f0_sr_data",      sr_data0,          32'h0000_00F0);

        snap0();
        fork
            applyStimulus(1'b0, 8'h3C, 1'b0, 1'b0, 1'b1);
            begin
                repeat (9 * CPB) @(negedge CLK);
                clr0 = 1'b1;
                repeat (CPB) @(negedge CLK);
                clr0 = 1'b0;
            end
        join
        repeat (8) @(negedge CLK);
        checkOutput("clear_valid_pulses", 32'(valid0 - v_s), 32'd1);
        checkOutput("clear_rx_data",      32'(rx_data0),     32'h3C);
        checkOutput("clear_sr_count",     32'(sr_count0),    32'd0);
        checkOutput("clear_led",          32'(led0),         32'h0);
        checkOutput("clear_sr_data",      sr_data0,          32'h0);

        checkOutput("no_err_with_valid", 32'(clash), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_rx_shiftreg.md
Name: uart_rx_shiftreg

Overview:
Parametrised UART receiver feeding a DEPTH-entry byte shift register. It is the next generation of the fixed 8N1 receive/shift path in ClockBaseTop. It adds configurable baud divisor, data width, parity mode, error flags, a fill count and a synchronous clear. The newest byte drives the board LEDs; the full history is exported for downstream frame decoding, e.g. 0x7E flag detection.

Parameters:
CLKS_PER_BIT, 1736, CLK cycles per bit (100 MHz / 57600 baud); legal range 8..65535.
DATA_BITS, 8, data bits per character; legal range 5..8.
PARITY, 0, 0 = none, 1 = even, 2 = odd.
DEPTH, 4, number of characters held in the shift register; minimum 2.

Ports:
CLK  in  1  system clock; the only clock.
reset  in  1  asynchronous, active-high reset.
uart_rx  in  1  asynchronous serial line; idles high.
sr_clear  in  1  synchronous clear of the shift register and fill count.
rx_data  out  DATA_BITS  last accepted character.
rx_valid  out  1  one-cycle pulse when a character is accepted.
parity_err  out  1  one-cycle pulse when a character is rejected for parity.
frame_err  out  1  one-cycle pulse when a character is rejected for a low stop bit.
sr_data  out  DEPTH*DATA_BITS  history; bits [DATA_BITS-1:0] hold the newest character.
sr_count  out  clog2(DEPTH+1)  number of valid entries; saturates at DEPTH.
led  out  8  newest character, zero-extended to 8 bits.

Behaviour:
- Reset (asynchronous, active-high):
  - synchronizer flops = 1; FSM = IDLE; bit and baud counters = 0.
  - all outputs = 0.
- Input synchronization: uart_rx passes through a 2-flop synchronizer; all sampling uses its output, rxs.
- FSM states: IDLE, START, DATA, PARITY, STOP, BREAK.
- IDLE:
  - a 1->0 transition on rxs moves to START and loads baud_cnt = CLKS_PER_BIT/2 - 1.
- START (bit sample taken when baud_cnt reaches 0):
  - rxs = 1: false start; return to IDLE with no flags.
  - rxs = 0: go to DATA; reload baud_cnt = CLKS_PER_BIT - 1.
- DATA:
  - on each baud_cnt expiry, sample rxs into the shift_in register, LSB first.
  - after DATA_BITS samples, go to PARITY if PARITY != 0, otherwise to STOP.
- PARITY:
  - sample the parity bit.
  - mismatch sets an internal par_bad flag.
  - even parity: XOR of data and parity bit must be 0; odd parity: it must be 1.
- STOP: sample the stop bit; outcome is decided in this priority order:
  - stop bit = 0: pulse frame_err; no update; go to BREAK.
  - else if par_bad: pulse parity_err; no update; go to IDLE.
  - else accept the character, as below, and go to IDLE.
- Character accept, all on the same cycle (the STOP sample edge + 1):
  - rx_data <= character; led <= character; rx_valid pulses for one cycle.
  - sr_data <= {sr_data[(DEPTH-1)*DATA_BITS-1:0], character}; the oldest entry is discarded.
  - sr_count increments, saturating at DEPTH.
- BREAK: wait until rxs = 1, then return to IDLE. A held-low line therefore produces exactly one frame_err.
- Latency: from the mid-point of the stop bit on rxs to rx_valid is 1 CLK; add 2 CLK for the synchronizer relative to uart_rx.
- A new start edge is accepted from the cycle after STOP exits. Back-to-back characters with a single stop bit must be received without loss.
- sr_clear:
  - zeroes sr_data, sr_count and led; does not disturb the FSM.
  - if asserted on the same cycle as an accept, the clear wins and the character is dropped from history.
  - rx_data and rx_valid still report the dropped character.
- reset asserted mid-character: the FSM returns to IDLE immediately and the partial character is discarded.
- Error pulses never coincide with rx_valid.
- All counters are unsigned, with width clog2(CLKS_PER_BIT) and clog2(DATA_BITS+1).

Decomposition:
- Package uart_pkg holds:
  - the FSM state enum;
  - PARITY_NONE / PARITY_EVEN / PARITY_ODD constants;
  - a clog2-based width function.
- One sub-module, uart_rx_core, covers the synchronizer, FSM and the rx_data/valid/err outputs.
- The top level holds the shift register, count, clear and led.

Test Plan:
- Default parameters, CLKS_PER_BIT = 16 in simulation; send 0xF4 8N1 -> rx_valid once, rx_data = 0xF4, led = 0xF4, sr_count = 1.
- Send 0x7E, 0x03, 0x01, 0x01, 0xFE back-to-back (DEPTH = 4) -> sr_data = {0x03, 0x01, 0x01, 0xFE} from oldest to newest, sr_count = 4 (saturated), five rx_valid pulses.
- Parity and framing errors:
  - PARITY = 1, send 0x01 with parity bit 0 -> parity_err pulse, no rx_valid, sr_data unchanged.
  - Same character with parity bit 1 -> accepted as 0x01.
- Glitches and break:
  - 0.25-bit-wide low glitch on uart_rx -> no pulses; FSM back in IDLE.
  - Stop bit forced to 0 on 0x55 -> a single frame_err pulse; the line held low for 3 bit times gives no further pulses.
  - The next 0xAA is received correctly.
- Reset and clear:
  - reset asserted during DATA of 0xC0, then released, then 0xF0 sent -> only 0xF0 accepted, sr_count = 1.
  - sr_clear on the same cycle as an accept -> sr_count = 0, led = 0, rx_valid still pulses.
